// File: rtl/csr_counter_array.sv
// csr_counter_array: machine performance counters (mcycle, minstret,
// mhpmcounter3..3+NUM_HPM-1) with split lo/hi CSR access and mcountinhibit.
// Optional macro CSR_USER_COUNTER_EN adds mcounteren (0x306) and the
// read-only user shadows cycle/instret/hpmcounterN (0xCxx).
module csr_counter_array #(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_csr_ex,
   input  logic [11:0]        csr_ofs_ex,
   input  logic [4:0]         csr_uimm_ex,
   input  logic [2:0]         csr_op2_ex,
   input  logic [31:0]        rs1_sel,
   input  logic               stall,
   input  logic               retire,
   input  logic [NUM_HPM-1:0] hpm_event,
   input  logic [1:0]         g_current_priv,
   output logic [31:0]        csr_cnt_rd_data,
   output logic               csr_cnt_hit,
   output logic               csr_cnt_illegal
);

   localparam int HI_W = CNT_WIDTH - 32;
   // Counter slots that exist: 0 (cycle), 2 (instret), 3.. (hpm)
   localparam logic [31:0] IMPL_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q [32];
   logic [CNT_WIDTH-1:0] cnt_d [32];
   logic [31:0]          inh_q, inh_d;
   logic [31:0]          inc;
   logic [31:0]          en_rd;
   logic [4:0]           idx;
   logic                 slot_ok, m_lo, m_hi, u_lo, u_hi, is_inh, is_en;
   logic                 cnt_acc, is_hi, wr_op, wr_en;
   logic [31:0]          src, wdata, rd_data;
   logic [63:0]          cnt_ext;

   // Address decode: slot 1 (time) is not owned by this block
   assign idx     = csr_ofs_ex[4:0];
   assign slot_ok = (idx != 5'd1);
   assign m_lo    = (csr_ofs_ex[11:5] == 7'h58) & slot_ok;
   assign m_hi    = (csr_ofs_ex[11:5] == 7'h5C) & slot_ok;
   assign is_inh  = (csr_ofs_ex == 12'h320);

`ifdef CSR_USER_COUNTER_EN
   logic [31:0] en_q, en_d;

   assign u_lo  = (csr_ofs_ex[11:5] == 7'h60) & slot_ok;
   assign u_hi  = (csr_ofs_ex[11:5] == 7'h64) & slot_ok;
   assign is_en = (csr_ofs_ex == 12'h306);
   assign en_rd = en_q;
   // Shadows are read-only at any privilege; lower privileges also need mcounteren
   assign csr_cnt_illegal = (u_lo | u_hi) &
                            (wr_op | ((g_current_priv != 2'b11) & ~en_q[idx]));
   assign en_d  = (wr_en & is_en) ? (wdata & IMPL_MASK) : en_q;

   // mcounteren register
   always_ff @(posedge clk) begin
      if (!rst_n) en_q <= '0;
      else        en_q <= en_d;
   end
`else
   logic unused_priv;

   assign u_lo            = 1'b0;
   assign u_hi            = 1'b0;
   assign is_en           = 1'b0;
   assign en_rd           = '0;
   assign csr_cnt_illegal = 1'b0;
   assign unused_priv     = ^g_current_priv;
`endif

   assign cnt_acc     = m_lo | m_hi | u_lo | u_hi;
   assign is_hi       = m_hi | u_hi;
   assign csr_cnt_hit = cnt_acc | is_inh | is_en;
   assign cnt_ext     = 64'(cnt_q[idx]);

   // Read mux from pre-update state; unimplemented slots hold zero
   always_comb begin
      rd_data = '0;
      if (cnt_acc)     rd_data = is_hi ? cnt_ext[63:32] : cnt_ext[31:0];
      else if (is_inh) rd_data = inh_q;
      else if (is_en)  rd_data = en_rd;
   end
   assign csr_cnt_rd_data = rd_data;

   // CSR read-modify-write data
   always_comb begin
      src = csr_op2_ex[2] ? {27'd0, csr_uimm_ex} : rs1_sel;
      case (csr_op2_ex[1:0])
         2'b01:   wdata = src;
         2'b10:   wdata = rd_data | src;
         2'b11:   wdata = rd_data & ~src;
         default: wdata = rd_data;
      endcase
   end

   assign wr_op = |csr_op2_ex[1:0];
   assign wr_en = ~stall & cmd_csr_ex & csr_cnt_hit & ~csr_cnt_illegal & wr_op;

   // Per-slot increment requests
   always_comb begin
      inc    = '0;
      inc[0] = 1'b1;
      inc[2] = retire;
      for (int i = 0; i < NUM_HPM; i++) inc[3+i] = hpm_event[i];
   end

   // Counter next state: a written half loads and the other holds, with no increment
   always_comb begin
      for (int k = 0; k < 32; k++) begin
         cnt_d[k] = cnt_q[k];
         if (wr_en && (m_lo || m_hi) && (idx == 5'(k))) begin
            if (m_hi) cnt_d[k] = {wdata[HI_W-1:0], cnt_q[k][31:0]};
            else      cnt_d[k] = {cnt_q[k][CNT_WIDTH-1:32], wdata};
         end else if (inc[k] && !inh_q[k]) begin
            cnt_d[k] = cnt_q[k] + ONE;
         end
         if (!IMPL_MASK[k]) cnt_d[k] = '0;
      end
   end

   assign inh_d = (wr_en & is_inh) ? (wdata & IMPL_MASK) : inh_q;

   // Counter and mcountinhibit registers, reset dominates write and increment
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 32; k++) cnt_q[k] <= '0;
         inh_q <= '0;
      end else begin
         for (int k = 0; k < 32; k++) cnt_q[k] <= cnt_d[k];
         inh_q <= inh_d;
      end
   end

endmodule

// File: tb/tb_csr_counter_array.sv
// Bench for csr_counter_array (NUM_HPM=2, CNT_WIDTH=64): directed CSR accesses
// push expected responses; a negedge monitor pops and compares.
module tb_csr_counter_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_csr_ex;
   logic [11:0] csr_ofs_ex;
   logic [4:0]  csr_uimm_ex;
   logic [2:0]  csr_op2_ex;
   logic [31:0] rs1_sel;
   logic        stall;
   logic        retire;
   logic [1:0]  hpm_event;
   logic [1:0]  g_current_priv;
   logic [31:0] csr_cnt_rd_data;
   logic        csr_cnt_hit;
   logic        csr_cnt_illegal;

   csr_counter_array #(.NUM_HPM(2), .CNT_WIDTH(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_csr_ex     (cmd_csr_ex),
      .csr_ofs_ex     (csr_ofs_ex),
      .csr_uimm_ex    (csr_uimm_ex),
      .csr_op2_ex     (csr_op2_ex),
      .rs1_sel        (rs1_sel),
      .stall          (stall),
      .retire         (retire),
      .hpm_event      (hpm_event),
      .g_current_priv (g_current_priv),
      .csr_cnt_rd_data(csr_cnt_rd_data),
      .csr_cnt_hit    (csr_cnt_hit),
      .csr_cnt_illegal(csr_cnt_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic        hit;
      logic        ill;
      logic        chk_d;
   } exp_t;

   exp_t sb[$];
   logic mon_en = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [11:0] a,
                      input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @0x%h: got 0x%h, expected 0x%h", nm, a, act, req);
      end
   endtask

   // Monitor: one expected response per presented CSR access
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", csr_ofs_ex, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            if (e.chk_d) chk("rd_data", e.addr, csr_cnt_rd_data, e.data);
            chk("hit", e.addr, {31'd0, csr_cnt_hit}, {31'd0, e.hit});
            chk("illegal", e.addr, {31'd0, csr_cnt_illegal}, {31'd0, e.ill});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic acc(input logic [11:0] a, input logic [2:0] op, input logic [31:0] rs1,
                      input logic [4:0] uimm, input logic stl, input logic [31:0] ed,
                      input logic eh, input logic ei, input logic ck);
      exp_t e;
      cmd_csr_ex  = 1'b1;
      csr_ofs_ex  = a;
      csr_op2_ex  = op;
      rs1_sel     = rs1;
      csr_uimm_ex = uimm;
      stall       = stl;
      e.addr = a; e.data = ed; e.hit = eh; e.ill = ei; e.chk_d = ck;
      sb.push_back(e);
      mon_en = 1'b1;
      tick();
      mon_en     = 1'b0;
      cmd_csr_ex = 1'b0;
      csr_op2_ex = 3'b000;
      stall      = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] ed);
      acc(a, 3'b000, 32'd0, 5'd0, 1'b0, ed, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] rs1,
                     input logic [4:0] uimm, input logic stl, input logic [31:0] ed);
      acc(a, op, rs1, uimm, stl, ed, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cmd_csr_ex = 1'b0; csr_ofs_ex = '0; csr_uimm_ex = '0;
      csr_op2_ex = '0; rs1_sel = '0; stall = 1'b0; retire = 1'b0;
      hpm_event = '0; g_current_priv = 2'b11;
      idle(3);
      rst_n = 1'b1;

      // reset state and free-running mcycle
      rd(12'hB00, 32'd0);
      rd(12'h320, 32'd0);
      rd(12'hB02, 32'd0);
      idle(7);
      rd(12'hB00, 32'd10);
      rd(12'hB80, 32'd0);

      // lo write then carry into hi
      wr(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'd12);
      rd(12'hB00, 32'hFFFF_FFFF);
      rd(12'hB00, 32'h0000_0000);
      rd(12'hB80, 32'h0000_0001);

      // minstret with inhibit bit 2
      retire = 1'b1; idle(3); retire = 1'b0;
      wr(12'h320, 3'b110, 32'd0, 5'd4, 1'b0, 32'd0);
      retire = 1'b1; idle(5); retire = 1'b0;
      rd(12'hB02, 32'd3);
      rd(12'h320, 32'd4);
      wr(12'h320, 3'b111, 32'd0, 5'd4, 1'b0, 32'd4);
      retire = 1'b1; idle(5); retire = 1'b0;
      rd(12'hB02, 32'd8);

      // unimplemented hpm slot is hit, zero, write ignored
      wr(12'hB05, 3'b001, 32'h1234, 5'd0, 1'b0, 32'd0);
      rd(12'hB05, 32'd0);
      rd(12'hB85, 32'd0);

      // hpm events and inhibit masking
      hpm_event = 2'b01; idle(2);
      hpm_event = 2'b11; idle(1);
      hpm_event = 2'b00;
      rd(12'hB03, 32'd3);
      rd(12'hB04, 32'd1);
      wr(12'h320, 3'b001, 32'hFFFF_FFFE, 5'd0, 1'b0, 32'd0);
      rd(12'h320, 32'h0000_001C);
      hpm_event = 2'b11; retire = 1'b1; idle(2);
      hpm_event = 2'b00; retire = 1'b0;
      rd(12'hB03, 32'd3);
      rd(12'hB02, 32'd8);
      rd(12'hB04, 32'd1);
      wr(12'h320, 3'b001, 32'd0, 5'd0, 1'b0, 32'h0000_001C);

      // addresses not owned
      acc(12'h340, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      acc(12'hB01, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

      // stall blocks the write; an unstalled write loads and suppresses increment
      hpm_event = 2'b01;
      wr(12'hB03, 3'b001, 32'h100, 5'd0, 1'b1, 32'd3);
      hpm_event = 2'b00;
      rd(12'hB03, 32'd4);
      hpm_event = 2'b01;
      wr(12'hB03, 3'b001, 32'h100, 5'd0, 1'b0, 32'd4);
      hpm_event = 2'b00;
      rd(12'hB03, 32'h100);
      wr(12'hB00, 3'b001, 32'h50, 5'd0, 1'b0, 32'h2A);
      rd(12'hB00, 32'h50);
      rd(12'hB80, 32'd1);
      wr(12'hB00, 3'b001, 32'h77, 5'd0, 1'b1, 32'h52);
      rd(12'hB00, 32'h53);

      // set op and hi-half write
      wr(12'hB04, 3'b010, 32'hF0, 5'd0, 1'b0, 32'd1);
      rd(12'hB04, 32'hF1);
      wr(12'hB83, 3'b001, 32'hAB, 5'd0, 1'b0, 32'd0);
      rd(12'hB03, 32'h100);
      rd(12'hB83, 32'hAB);

`ifdef CSR_USER_COUNTER_EN
      g_current_priv = 2'b00;
      acc(12'hC00, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      g_current_priv = 2'b11;
      wr(12'h306, 3'b110, 32'd0, 5'd1, 1'b0, 32'd0);
      acc(12'hB00, 3'b001, 32'h1000, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      g_current_priv = 2'b00;
      rd(12'hC00, 32'h1000);
      acc(12'hC02, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      g_current_priv = 2'b11;
      acc(12'hC00, 3'b001, 32'd5, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      rd(12'hB00, 32'h1003);
      rd(12'h306, 32'd1);
`else
      acc(12'h306, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      g_current_priv = 2'b00;
      acc(12'hC00, 3'b000, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      g_current_priv = 2'b11;
`endif

      // reset during a write with increments pending
      retire = 1'b1; hpm_event = 2'b11; rst_n = 1'b0;
      wr(12'hB02, 3'b001, 32'h99, 5'd0, 1'b0, 32'd8);
      retire = 1'b0; hpm_event = 2'b00; rst_n = 1'b1;
      rd(12'hB02, 32'd0);
      rd(12'hB03, 32'd0);
      rd(12'hB83, 32'd0);
      rd(12'h320, 32'd0);
      rd(12'hB00, 32'd4);
      rd(12'hB80, 32'd0);
`ifdef CSR_USER_COUNTER_EN
      rd(12'h306, 32'd0);
`endif

      tick();
      chk("scoreboard_drain", 12'h000, sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
